fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time from the byte FIFO and
// serialises each as an 8N1 UART frame on tx. All outputs are registered.
module fifo_uart_tx #(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("CLK_FREQ / BAUD must be at least 2");
    end

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cnt_wrap;

    assign cnt_wrap = (cnt_q == CNT_LAST);

    // Next-state logic: frame sequencing, baud counting and line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                // Empty flag is only looked at here, so the FIFO's late
                // flag update after a pop is never seen mid-frame.
                if (!fifo_empty) begin
                    shift_d = fifo_data;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_wrap) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = shift_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; in-flight word is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_read_en = rd_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a small instance (4 clocks per bit) and a default
// instance, fed from a queue-based FIFO model; every cycle's outputs are
// compared against a frame-timeline reference model.
module tb_fifo_uart_tx;

    localparam int FRAME_BITS = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       use_def;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    logic empty_a, rd_a, tx_a, busy_a, done_a;
    logic empty_b, rd_b, tx_b, busy_b, done_b;

    // Only the selected instance sees a non-empty FIFO.
    assign empty_a = use_def ? 1'b1 : fifo_empty;
    assign empty_b = use_def ? fifo_empty : 1'b1;

    fifo_uart_tx #(
        .CLK_FREQ  (40),
        .BAUD      (10),
        .DATA_WIDTH(8)
    ) dut_a (
        .clock       (clock),
        .reset       (reset),
        .fifo_empty  (empty_a),
        .fifo_data   (fifo_data),
        .fifo_read_en(rd_a),
        .tx          (tx_a),
        .busy        (busy_a),
        .frame_done  (done_a)
    );

    fifo_uart_tx dut_b (
        .clock       (clock),
        .reset       (reset),
        .fifo_empty  (empty_b),
        .fifo_data   (fifo_data),
        .fifo_read_en(rd_b),
        .tx          (tx_b),
        .busy        (busy_b),
        .frame_done  (done_b)
    );

    always #5 clock = ~clock;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] fifo_q[$];
    int         exp_start[$];
    int         exp_end[$];
    logic [7:0] exp_bytes[$];
    int         exp_cpb;

    function automatic logic [3:0] observed();
        return use_def ? {rd_b, tx_b, busy_b, done_b} : {rd_a, tx_a, busy_a, done_a};
    endfunction

    // Reference: frame i pops at exp_start, line holds start/data/stop bits
    // for exp_cpb cycles each, then frame_done; cut short at exp_end.
    function automatic logic [3:0] model(int c);
        logic rd, txv, bz, fd;
        rd = 1'b0; txv = 1'b1; bz = 1'b0; fd = 1'b0;
        foreach (exp_start[i]) begin
            int k;
            int b;
            k = c - exp_start[i];
            if (k >= 0 && c < exp_end[i]) begin
                if (k < FRAME_BITS * exp_cpb) begin
                    bz = 1'b1;
                    rd = (k == 0);
                    b  = k / exp_cpb;
                    if (b == 0) txv = 1'b0;
                    else if (b <= 8) txv = exp_bytes[i][b-1];
                    else txv = 1'b1;
                end else if (k == FRAME_BITS * exp_cpb) begin
                    fd = 1'b1;
                end
            end
        end
        return {rd, txv, bz, fd};
    endfunction

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock; the FIFO model pops after the edge that ends a read cycle,
    // so its flag and head word update one cycle late.
    task automatic tick();
        logic rd;
        rd = use_def ? rd_b : rd_a;
        @(posedge clock);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic clear_model(int cpb);
        exp_start.delete();
        exp_end.delete();
        exp_bytes.delete();
        exp_cpb = cpb;
    endtask

    task automatic add_frame(int s, int e, logic [7:0] b);
        exp_start.push_back(s);
        exp_end.push_back(e);
        exp_bytes.push_back(b);
    endtask

    task automatic run_stream(string name, int ncycles, int reset_at, int push_at,
                              logic [7:0] push_val);
        logic [3:0] exp, obs;
        refresh();
        for (int c = 0; c < ncycles; c++) begin
            exp = model(c);
            obs = observed();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: {rd,tx,busy,done} got %b expected %b",
                         name, c, obs, exp);
            end
            reset = (c == reset_at);
            if (c == push_at) begin
                fifo_q.push_back(push_val);
                refresh();
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({rd_a, tx_a, busy_a, done_a} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_small: got %b expected 0100", {rd_a, tx_a, busy_a, done_a});
        end
        vectors++;
        if ({rd_b, tx_b, busy_b, done_b} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_default: got %b expected 0100", {rd_b, tx_b, busy_b, done_b});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        clear_model(4);
        run_stream("idle", 100, -1, -1, 8'h00);
    endtask

    task automatic test_single();
        clear_model(4);
        fifo_q.push_back(8'hA5);
        add_frame(1, 42, 8'hA5);
        run_stream("single_a5", 44, -1, -1, 8'h00);
    endtask

    task automatic test_back_to_back();
        clear_model(4);
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        add_frame(1, 42, 8'h00);
        add_frame(42, 83, 8'hFF);
        run_stream("back_to_back", 85, -1, -1, 8'h00);
    endtask

    task automatic test_head_change();
        // New head word appears during data bits; frame in flight keeps 3C.
        clear_model(4);
        fifo_q.push_back(8'h3C);
        add_frame(1, 42, 8'h3C);
        add_frame(42, 83, 8'hC3);
        run_stream("head_change", 85, -1, 15, 8'hC3);
    endtask

    task automatic test_reset_mid();
        // Reset during data bit 3 (cycle 17); second word popped right after.
        clear_model(4);
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h96);
        add_frame(1, 18, 8'h5A);
        add_frame(19, 60, 8'h96);
        run_stream("reset_mid", 62, 17, -1, 8'h00);
    endtask

    task automatic test_reset_wins();
        clear_model(4);
        fifo_q.push_back(8'hE7);
        add_frame(2, 43, 8'hE7);
        run_stream("reset_wins", 45, 0, -1, 8'h00);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(1, 4);
            clear_model(4);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                fifo_q.push_back(b);
                add_frame(1 + i * 41, 42 + i * 41, b);
            end
            run_stream("random", n * 41 + 3, -1, -1, 8'h00);
        end
    endtask

    task automatic test_defaults();
        use_def = 1'b1;
        clear_model(234);
        fifo_q.push_back(8'h55);
        add_frame(1, 2342, 8'h55);
        run_stream("defaults_55", 2345, -1, -1, 8'h00);
        use_def = 1'b0;
    endtask

    initial begin
        use_def    = 1'b0;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_head_change();
        test_reset_mid();
        test_reset_wins();
        test_random();
        test_defaults();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
